// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_sequencer
// Purpose  : Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
//            It stalls on the shared memory port's mem_ready and halts on
//            SYSCALL. Strobes are decoded from state and the latched
//            opcode/funct. In DECODE they use the live opcode/funct.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             PCWrite,
  output logic [1:0]       pc_src,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             ALUSrc,
  output logic [5:0]       ALUOp,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             WriDataSel,
  output logic             JumpSel,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Instruction classes. Unknown encodings fold into C_NOP.
  typedef enum logic [3:0] {
    C_NOP  = 4'd0,
    C_J    = 4'd1,
    C_JAL  = 4'd2,
    C_JR   = 4'd3,
    C_SYS  = 4'd4,
    C_LW   = 4'd5,
    C_SW   = 4'd6,
    C_BNE  = 4'd7,
    C_ADDI = 4'd8,
    C_XORI = 4'd9,
    C_RALU = 4'd10
  } cls_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SYS   = 6'b001100;

  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_XOR  = 6'b100110;
  localparam logic [5:0] ALU_IDLE = 6'b101100;

  state_t           state_q;
  state_t           state_d;
  logic [5:0]       op_q;
  logic [5:0]       fn_q;
  logic [CNT_W-1:0] retired_q;
  cls_t             cls;

  function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
    cls_t c;
    c = C_NOP;
    case (op)
      OP_LW:   c = C_LW;
      OP_SW:   c = C_SW;
      OP_J:    c = C_J;
      OP_JAL:  c = C_JAL;
      OP_BNE:  c = C_BNE;
      OP_XORI: c = C_XORI;
      OP_ADDI: c = C_ADDI;
      OP_RTYPE: begin
        case (fn)
          FN_JR:                  c = C_JR;
          FN_SYS:                 c = C_SYS;
          FN_ADD, FN_SUB, FN_SLT: c = C_RALU;
          default:                c = C_NOP;
        endcase
      end
      default: c = C_NOP;
    endcase
    return c;
  endfunction

  // Next-state and strobe decode. Reset forces every strobe to its default.
  always_comb begin
    state_d    = S_FETCH;
    PCWrite    = 1'b0;
    pc_src     = 2'd0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    ALUSrc     = 1'b0;
    ALUOp      = ALU_IDLE;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    WriDataSel = 1'b0;
    JumpSel    = 1'b0;
    halted     = 1'b0;
    cls        = (state_q == S_DECODE) ? classify(opcode, funct) : classify(op_q, fn_q);
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUOp   = ALU_ADD;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = S_DECODE;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DECODE: begin
          case (cls)
            C_J: begin
              PCWrite = 1'b1;
              pc_src  = 2'd2;
            end
            C_JAL: begin
              PCWrite  = 1'b1;
              pc_src   = 2'd2;
              RegWrite = 1'b1;
            end
            C_JR: begin
              PCWrite = 1'b1;
              pc_src  = 2'd3;
              JumpSel = 1'b1;
            end
            C_NOP:   state_d = S_FETCH;
            C_SYS:   state_d = S_HALT;
            default: state_d = S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (cls)
            C_BNE: begin
              ALUOp   = ALU_SUB;
              PCWrite = ~zero;
              pc_src  = 2'd1;
            end
            C_LW, C_SW: begin
              ALUSrc  = 1'b1;
              ALUOp   = ALU_ADD;
              state_d = S_MEM;
            end
            C_ADDI: begin
              ALUSrc  = 1'b1;
              ALUOp   = ALU_ADD;
              state_d = S_WB;
            end
            C_XORI: begin
              ALUSrc  = 1'b1;
              ALUOp   = ALU_XOR;
              state_d = S_WB;
            end
            C_RALU: begin
              ALUOp   = fn_q;
              state_d = S_WB;
            end
            default: state_d = S_FETCH;
          endcase
        end
        S_MEM: begin
          // Strobe is held every cycle until the memory acknowledges.
          MemRead  = (cls == C_LW);
          MemWrite = (cls == C_SW);
          if (!mem_ready)         state_d = S_MEM;
          else if (cls == C_LW)   state_d = S_WB;
          else                    state_d = S_FETCH;
        end
        S_WB: begin
          RegWrite   = 1'b1;
          WriDataSel = 1'b1;
          RegDst     = (cls == C_RALU);
          MemtoReg   = (cls == C_LW);
        end
        S_HALT: begin
          halted  = 1'b1;
          state_d = S_HALT;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // State register, instruction latch and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= 6'd0;
      fn_q      <= 6'd0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
      if (state_d == S_FETCH &&
          (state_q == S_DECODE || state_q == S_EXEC ||
           state_q == S_MEM    || state_q == S_WB)) begin
        retired_q <= retired_q + 1'b1;
      end
    end
  end

  assign state   = reset ? S_FETCH : state_q;
  assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_sequencer
// Purpose  : Directed scoreboard bench for multicycle_sequencer. Each cycle
//            the driver applies inputs and queues the hand-derived output
//            set. A monitor compares that set on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

  localparam logic [5:0] R0   = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] JAL  = 6'b000011;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] XORI = 6'b001110;
  localparam logic [5:0] UNK  = 6'b111111;
  localparam logic [5:0] FADD = 6'b100000;
  localparam logic [5:0] FJR  = 6'b001000;
  localparam logic [5:0] FSYS = 6'b001100;
  localparam logic [5:0] AADD = 6'b100000;
  localparam logic [5:0] ASUB = 6'b100010;
  localparam logic [5:0] AXOR = 6'b100110;
  localparam logic [5:0] AIDL = 6'b101100;

  typedef struct packed {
    logic [2:0]  st;
    logic        pcw;
    logic [1:0]  pcs;
    logic        irw;
    logic        mr;
    logic        mw;
    logic        as;
    logic [5:0]  aop;
    logic        rw;
    logic        rd;
    logic        m2r;
    logic        wds;
    logic        js;
    logic        h;
    logic [31:0] ret;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        mem_ready = 1'b0;
  logic        zero = 1'b0;
  logic        PCWrite, IRWrite, MemRead, MemWrite, ALUSrc;
  logic        RegWrite, RegDst, MemtoReg, WriDataSel, JumpSel, halted;
  logic [1:0]  pc_src;
  logic [5:0]  ALUOp;
  logic [2:0]  state;
  logic [31:0] retired;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  multicycle_sequencer #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .zero(zero), .PCWrite(PCWrite), .pc_src(pc_src),
    .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .WriDataSel(WriDataSel), .JumpSel(JumpSel),
    .halted(halted), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  // Field order: state, PCWrite, pc_src, IRWrite, MemRead, MemWrite, ALUSrc,
  // ALUOp, RegWrite, RegDst, MemtoReg, WriDataSel, JumpSel, halted, retired
  function automatic exp_t mk(input logic [2:0] st, input logic pcw,
      input logic [1:0] pcs, input logic irw, input logic mr, input logic mw,
      input logic as, input logic [5:0] aop, input logic rw, input logic rd,
      input logic m2r, input logic wds, input logic js, input logic h,
      input logic [31:0] ret);
    exp_t e;
    e = '{st, pcw, pcs, irw, mr, mw, as, aop, rw, rd, m2r, wds, js, h, ret};
    return e;
  endfunction

  // One cycle: apply inputs just after the rising edge and queue the outputs
  // expected for the rest of that cycle.
  task automatic drive(input logic rst, input logic [5:0] op,
      input logic [5:0] fn, input logic rdy, input logic z, input exp_t e);
    @(posedge clk);
    #1;
    reset     = rst;
    opcode    = op;
    funct     = fn;
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(e);
  endtask

  // Monitor: compare whatever the driver queued against the live outputs.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{state, PCWrite, pc_src, IRWrite, MemRead, MemWrite, ALUSrc,
              ALUOp, RegWrite, RegDst, MemtoReg, WriDataSel, JumpSel, halted,
              retired};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL cyc%0d t=%0t: got st=%0d pcw=%b pcs=%0d irw=%b mr=%b mw=%b as=%b aop=%b rw=%b rd=%b m2r=%b wds=%b js=%b h=%b ret=%0d | want st=%0d pcw=%b pcs=%0d irw=%b mr=%b mw=%b as=%b aop=%b rw=%b rd=%b m2r=%b wds=%b js=%b h=%b ret=%0d",
                   n_cmp, $time, a.st, a.pcw, a.pcs, a.irw, a.mr, a.mw, a.as,
                   a.aop, a.rw, a.rd, a.m2r, a.wds, a.js, a.h, a.ret,
                   e.st, e.pcw, e.pcs, e.irw, e.mr, e.mw, e.as, e.aop, e.rw,
                   e.rd, e.m2r, e.wds, e.js, e.h, e.ret);
        end
      end
    end
  end

  initial begin
    // Reset: defaults, FETCH, retired cleared.
    drive(1, R0, R0, 1, 0, mk(0, 0,0,0,0,0,0, AIDL, 0,0,0,0,0,0, 0));
    drive(1, R0, R0, 1, 0, mk(0, 0,0,0,0,0,0, AIDL, 0,0,0,0,0,0, 0));

    // ADD: 0,1,2,4 then FETCH with retired=1.
    drive(0, R0, FADD, 1, 0, mk(0, 1,0,1,1,0,0, AADD, 0,0,0,0,0,0, 0));
    drive(0, R0, FADD, 1, 0, mk(1, 0,0,0,0,0,0, AIDL, 0,0,0,0,0,0, 0));
    drive(0, R0, FADD, 1, 0, mk(2, 0,0,0,0,0,0, AADD, 0,0,0,0,0,0, 0));
    drive(0, R0, FADD, 1, 0, mk(4, 0,0,0,0,0,0, AIDL, 1,1,0,1,0,0, 0));

    // LW: 2 fetch waits, 3 memory waits, MemRead held; 10 cycles.
    drive(0, LW, R0, 0, 0, mk(0, 0,0,0,1,0,0, AADD, 0,0,0,0,0,0, 1));
    drive(0, LW, R0, 0, 0, mk(0, 0,0,0,1,0,0, AADD, 0,0,0,0,0,0, 1));
    drive(0, LW, R0, 1, 0, mk(0, 1,0,1,1,0,0, AADD, 0,0,0,0,0,0, 1));
    drive(0, LW, R0, 1, 0, mk(1, 0,0,0,0,0,0, AIDL, 0,0,0,0,0,0, 1));
    drive(0, LW, R0, 1, 0, mk(2, 0,0,0,0,0,1, AADD, 0,0,0,0,0,0, 1));
    drive(0, LW, R0, 0, 0, mk(3, 0,0,0,1,0,0, AIDL, 0,0,0,0,0,0, 1));
    drive(0, LW, R0, 0, 0, mk(3, 0,0,0,1,0,0, AIDL, 0,0,0,0,0,0, 1));
    drive(0, LW, R0, 0, 0, mk(3, 0,0,0,1,0,0, AIDL, 0,0,0,0,0,0, 1));
    drive(0, LW, R0, 1, 0, mk(3, 0,0,0,1,0,0, AIDL, 0,0,0,0,0,0, 1));
    drive(0, LW, R0, 1, 0, mk(4, 0,0,0,0,0,0, AIDL, 1,0,1,1,0,0, 1));

    // BNE taken (zero=0), then not taken (zero=1).
    drive(0, BNE, R0, 1, 0, mk(0, 1,0,1,1,0,0, AADD, 0,0,0,0,0,0, 2));
    drive(0, BNE, R0, 1, 0, mk(1, 0,0,0,0,0,0, AIDL, 0,0,0,0,0,0, 2));
    drive(0, BNE, R0, 1, 0, mk(2, 1,1,0,0,0,0, ASUB, 0,0,0,0,0,0, 2));
    drive(0, BNE, R0, 1, 1, mk(0, 1,0,1,1,0,0, AADD, 0,0,0,0,0,0, 3));
    drive(0, BNE, R0, 1, 1, mk(1, 0,0,0,0,0,0, AIDL, 0,0,0,0,0,0, 3));
    drive(0, BNE, R0, 1, 1, mk(2, 0,1,0,0,0,0, ASUB, 0,0,0,0,0,0, 3));

    // JAL then JR, two cycles each.
    drive(0, JAL, R0, 1, 0, mk(0, 1,0,1,1,0,0, AADD, 0,0,0,0,0,0, 4));
    drive(0, JAL, R0, 1, 0, mk(1, 1,2,0,0,0,0, AIDL, 1,0,0,0,0,0, 4));
    drive(0, R0, FJR, 1, 0, mk(0, 1,0,1,1,0,0, AADD, 0,0,0,0,0,0, 5));
    drive(0, R0, FJR, 1, 0, mk(1, 1,3,0,0,0,0, AIDL, 0,0,0,0,1,0, 5));

    // Unknown opcode takes the NOOP path and still retires.
    drive(0, UNK, UNK, 1, 0, mk(0, 1,0,1,1,0,0, AADD, 0,0,0,0,0,0, 6));
    drive(0, UNK, UNK, 1, 0, mk(1, 0,0,0,0,0,0, AIDL, 0,0,0,0,0,0, 6));

    // XORI: immediate operand, XOR, write to rt.
    drive(0, XORI, R0, 1, 0, mk(0, 1,0,1,1,0,0, AADD, 0,0,0,0,0,0, 7));
    drive(0, XORI, R0, 1, 0, mk(1, 0,0,0,0,0,0, AIDL, 0,0,0,0,0,0, 7));
    drive(0, XORI, R0, 1, 0, mk(2, 0,0,0,0,0,1, AXOR, 0,0,0,0,0,0, 7));
    drive(0, XORI, R0, 1, 0, mk(4, 0,0,0,0,0,0, AIDL, 1,0,0,1,0,0, 7));

    // SW aborted by reset while stalled in MEM.
    drive(0, SW, R0, 1, 0, mk(0, 1,0,1,1,0,0, AADD, 0,0,0,0,0,0, 8));
    drive(0, SW, R0, 1, 0, mk(1, 0,0,0,0,0,0, AIDL, 0,0,0,0,0,0, 8));
    drive(0, SW, R0, 1, 0, mk(2, 0,0,0,0,0,1, AADD, 0,0,0,0,0,0, 8));
    drive(0, SW, R0, 0, 0, mk(3, 0,0,0,0,1,0, AIDL, 0,0,0,0,0,0, 8));
    drive(1, SW, R0, 0, 0, mk(0, 0,0,0,0,0,0, AIDL, 0,0,0,0,0,0, 8));
    // A complete SW after reset: four cycles.
    drive(0, SW, R0, 1, 0, mk(0, 1,0,1,1,0,0, AADD, 0,0,0,0,0,0, 0));
    drive(0, SW, R0, 1, 0, mk(1, 0,0,0,0,0,0, AIDL, 0,0,0,0,0,0, 0));
    drive(0, SW, R0, 1, 0, mk(2, 0,0,0,0,0,1, AADD, 0,0,0,0,0,0, 0));
    drive(0, SW, R0, 1, 0, mk(3, 0,0,0,0,1,0, AIDL, 0,0,0,0,0,0, 0));

    // SYSCALL: sticky HALT for 20 cycles, retired unchanged.
    drive(0, R0, FSYS, 1, 0, mk(0, 1,0,1,1,0,0, AADD, 0,0,0,0,0,0, 1));
    drive(0, R0, FSYS, 1, 0, mk(1, 0,0,0,0,0,0, AIDL, 0,0,0,0,0,0, 1));
    for (int i = 0; i < 20; i++) begin
      drive(0, LW, R0, logic'(i % 2), logic'(i % 3 == 0),
            mk(5, 0,0,0,0,0,0, AIDL, 0,0,0,0,0,1, 1));
    end
    // Reset leaves HALT and clears the counter.
    drive(1, R0, R0, 1, 0, mk(0, 0,0,0,0,0,0, AIDL, 0,0,0,0,0,0, 1));
    drive(0, R0, R0, 0, 0, mk(0, 0,0,0,1,0,0, AADD, 0,0,0,0,0,0, 0));

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
